// File: rtl/tt_sel_seq.sv
// Design-select sequencer: drives the sel_rst_n / sel_inc / ena pads to
// step a shared mux to the requested design address, then re-enables it.
module tt_sel_seq #(
  parameter int ADDR_W   = 10,
  parameter int MAX_ADDR = 1023,
  parameter int PULSE_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  input  logic              abort,
  output logic              sel_rst_n,
  output logic              sel_inc,
  output logic              ena,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(PULSE_W - 1);
  localparam logic [ADDR_W:0] MAX_EXT = (ADDR_W + 1)'(MAX_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    DIS,
    RST,
    GAP,
    INC_HI,
    INC_LO,
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              lat_q, lat_d;

  logic ready_q, ready_d;
  logic rstn_q, rstn_d;
  logic inc_q, inc_d;
  logic ena_q, ena_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic last;
  logic addr_bad;

  assign last     = (tmr_q == '0);
  assign addr_bad = ({1'b0, req_addr} > MAX_EXT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    err_d   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // ready_q low on the first cycle after reset blocks accept there
          if (req_valid && ready_q) begin
            if (addr_bad) begin
              err_d = 1'b1;
            end else begin
              state_d = DIS;
              cnt_d   = req_addr;
              lat_d   = req_ena;
            end
          end
        end
        DIS: if (last) state_d = RST;
        RST: if (last) state_d = GAP;
        GAP: begin
          if (last) state_d = (cnt_q != '0) ? INC_HI : FIN;
        end
        INC_HI: if (last) state_d = INC_LO;
        INC_LO: begin
          if (last) begin
            cnt_d   = cnt_q - ADDR_W'(1);
            state_d = (cnt_q == ADDR_W'(1)) ? FIN : INC_HI;
          end
        end
        FIN: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Timer reloads on every state change, otherwise counts down to zero
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      tmr_d = TLOAD;
    end else if (!last) begin
      tmr_d = tmr_q - TW'(1);
    end
  end

  // Outputs are decoded from the next state so the pads come from flops
  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    rstn_d  = (state_d != RST);
    inc_d   = (state_d == INC_HI);
    done_d  = (state_d == FIN);
    ena_d   = 1'b0;
    if (abort) begin
      ena_d = 1'b0;
    end else if (state_d == FIN) begin
      ena_d = lat_q;
    end else if (state_d == IDLE) begin
      ena_d = ena_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= 1'b0;
      ready_q <= 1'b0;
      rstn_q  <= 1'b0;
      inc_q   <= 1'b0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      ready_q <= ready_d;
      rstn_q  <= rstn_d;
      inc_q   <= inc_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign sel_rst_n = rstn_q;
  assign sel_inc   = inc_q;
  assign ena       = ena_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Bench for tt_sel_seq: expected pad waveforms are derived from the
// phase arithmetic of a select sequence, offset by offset from accept.
module tb_tt_sel_seq;

  localparam int AW   = 6;
  localparam int MAXA = 20;
  localparam int PW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_ena = 1'b0;
  logic          abort = 1'b0;
  logic          sel_rst_n, sel_inc, ena, busy, done, err;

  int   checks = 0;
  int   errors = 0;
  logic exp_ena = 1'b0;

  tt_sel_seq #(.ADDR_W(AW), .MAX_ADDR(MAXA), .PULSE_W(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_ena   (req_ena),
    .abort     (abort),
    .sel_rst_n (sel_rst_n),
    .sel_inc   (sel_inc),
    .ena       (ena),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic issue(input int a, input logic e);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a[AW-1:0];
    req_ena   = e;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Walks a whole accepted sequence plus the first idle cycle after it
  task automatic check_seq(input int a, input logic e, input string tag);
    int   len;
    int   nb, nrl, ninc;
    logic pinc;
    logic x_rl, x_inc, x_en, x_dn;
    len  = PW * (3 + 2 * a) + 1;
    nb   = 0;
    nrl  = 0;
    ninc = 0;
    pinc = 1'b0;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      x_rl  = !(t >= PW && t < 2 * PW);
      x_inc = (t >= 3 * PW) && (t < len - 1) && (((t - 3 * PW) / PW) % 2 == 0);
      x_dn  = (t == len - 1);
      x_en  = x_dn ? e : 1'b0;
      checks++;
      if ({busy, sel_rst_n, sel_inc, ena, done, req_ready, err} !==
          {1'b1, x_rl, x_inc, x_en, x_dn, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s t=%0d got b/rn/inc/ena/dn/rdy/err=%b%b%b%b%b%b%b want %b%b%b%b%b00",
                 tag, t, busy, sel_rst_n, sel_inc, ena, done, req_ready, err,
                 1'b1, x_rl, x_inc, x_en, x_dn);
      end
      if (busy) nb++;
      if (!sel_rst_n) nrl++;
      if (sel_inc && !pinc) ninc++;
      pinc = sel_inc;
    end
    checks++;
    if (nb !== len) begin
      errors++;
      $display("FAIL %s busy_len got %0d want %0d", tag, nb, len);
    end
    checks++;
    if (nrl !== PW) begin
      errors++;
      $display("FAIL %s rst_low got %0d want %0d", tag, nrl, PW);
    end
    checks++;
    if (ninc !== a) begin
      errors++;
      $display("FAIL %s inc_pulses got %0d want %0d", tag, ninc, a);
    end
    exp_ena = e;
    @(negedge clk);
    checks++;
    if ({busy, req_ready, done, ena, sel_inc, sel_rst_n} !==
        {1'b0, 1'b1, 1'b0, e, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s post got b/rdy/dn/ena/inc/rn=%b%b%b%b%b%b want 01%b01",
               tag, busy, req_ready, done, ena, sel_inc, sel_rst_n, 1'b0, e);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({busy, req_ready, done, err, ena, sel_inc, sel_rst_n} !==
        {1'b0, 1'b1, 1'b0, 1'b0, exp_ena, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s idle got b/rdy/dn/err/ena/inc/rn=%b%b%b%b%b%b%b want 0100%b01",
               tag, busy, req_ready, done, err, ena, sel_inc, sel_rst_n, exp_ena);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({sel_rst_n, sel_inc, ena, busy, done, err, req_ready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold got %b want 0000000",
               {sel_rst_n, sel_inc, ena, busy, done, err, req_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({sel_rst_n, req_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_rel got rn/rdy=%b%b want 00", sel_rst_n, req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({sel_rst_n, req_ready, busy} !== 3'b110) begin
      errors++;
      $display("FAIL reset_edge got rn/rdy/b=%b%b%b want 110",
               sel_rst_n, req_ready, busy);
    end
    exp_ena = 1'b0;
  endtask

  task automatic test_addr3();
    issue(3, 1'b1);
    check_seq(3, 1'b1, "addr3");
  endtask

  task automatic test_addr0();
    issue(0, 1'b1);
    check_seq(0, 1'b1, "addr0");
  endtask

  task automatic test_err(input int a);
    issue(a, ~exp_ena);
    @(negedge clk);
    checks++;
    if ({err, busy, sel_rst_n, sel_inc, ena, req_ready} !==
        {1'b1, 1'b0, 1'b1, 1'b0, exp_ena, 1'b1}) begin
      errors++;
      $display("FAIL err_%0d got err/b/rn/inc/ena/rdy=%b%b%b%b%b%b want 1010%b1",
               a, err, busy, sel_rst_n, sel_inc, ena, req_ready, exp_ena);
    end
    @(negedge clk);
    check_idle("err_after");
  endtask

  task automatic test_random();
    int   a;
    logic e;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        test_err($urandom_range(MAXA + 1, (1 << AW) - 1));
      end else begin
        a = $urandom_range(0, 6);
        e = 1'($urandom_range(0, 1));
        issue(a, e);
        check_seq(a, e, "rand");
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_abort_inc();
    issue(4, 1'b1);
    for (int t = 0; t <= 5 * PW; t++) @(negedge clk);
    checks++;
    if (sel_inc !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre sel_inc got %b want 1", sel_inc);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_ena = 1'b0;
    @(negedge clk);
    check_idle("abort_inc");
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_after got dn/b=%b%b want 00", done, busy);
      end
    end
  endtask

  task automatic test_abort_idle();
    issue(0, 1'b1);
    check_seq(0, 1'b1, "pre_abort");
    @(negedge clk);
    abort     = 1'b1;
    req_valid = 1'b1;
    req_addr  = AW'(2);
    req_ena   = 1'b1;
    @(posedge clk);
    #1;
    abort     = 1'b0;
    req_valid = 1'b0;
    exp_ena   = 1'b0;
    @(negedge clk);
    check_idle("abort_idle");
    @(negedge clk);
    check_idle("abort_idle2");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = AW'(2);
    req_ena   = 1'b0;
    @(posedge clk);
    #1;
    req_addr = AW'(3);
    req_ena  = 1'b1;
    check_seq(2, 1'b0, "b2b_first");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_seq(3, 1'b1, "b2b_second");
  endtask

  task automatic test_reset_mid();
    issue(2, 1'b1);
    for (int t = 0; t <= PW; t++) @(negedge clk);
    checks++;
    if (sel_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre sel_rst_n got %b want 0", sel_rst_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel_rst_n, sel_inc, ena, busy, done, err, req_ready} !== 7'b0) begin
      errors++;
      $display("FAIL rstmid_async got %b want 0000000",
               {sel_rst_n, sel_inc, ena, busy, done, err, req_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_ena = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({sel_rst_n, req_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL rstmid_rel got rn/rdy/b/dn=%b%b%b%b want 1100",
               sel_rst_n, req_ready, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_addr3();
    test_addr0();
    test_err(MAXA + 1);
    test_random();
    test_abort_inc();
    test_abort_idle();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
